div_32b_seq: RTL and testbench

DIV_32B_SEQ -- requirements
Module: div_32b_seq

---
 rtl/div_pkg.sv | 19 +
 rtl/sub_32b.sv | 19 +
 rtl/div_32b_seq.sv | 138 +++++++++++++
 tb/tb_div_32b_seq.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared constants and FSM encoding for the sequential divider
package div_pkg;

    // Operand/result width of the divider datapath.
    localparam int WIDTH = 32;

    // Width of the iteration counter (counts 0..31).
    localparam int CNT_W = 5;

    // Quotient reported when the captured divisor is zero.
    localparam logic [WIDTH-1:0] DBZ_QUOTIENT = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/sub_32b.sv
// rtl/sub_32b.sv - 32-bit subtractor, diff = a - b - c_in, c_out=1 means no borrow
//
// Ports:
//   a, b   : 32-bit operands
//   c_in   : borrow in (1 subtracts an extra one)
//   diff   : a - b - c_in, modulo 2^32
//   c_out  : 1 when no borrow out of bit 31 (a >= b + c_in)
module sub_32b (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        c_in,
    output logic [31:0] diff,
    output logic        c_out
);

    // Two's-complement subtract: a + ~b + 1, with the +1 withheld on borrow-in.
    assign {c_out, diff} = {1'b0, a} + {1'b0, ~b} + {32'd0, ~c_in};

endmodule

// File: rtl/div_32b_seq.sv
// rtl/div_32b_seq.sv - 32-bit unsigned restoring divider, one quotient bit per cycle
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : request pulse, accepted only in IDLE when done is low
//   dividend, divisor   : operands, captured on the accepted start
//   busy                : high while iterating
//   done                : one-cycle pulse when the results below update
//   quotient, remainder : results, held until the next accepted start completes
//   div_by_zero         : set with done when the captured divisor was zero
module div_32b_seq #(
    parameter int WIDTH = div_pkg::WIDTH,
    parameter int ITER  = div_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    import div_pkg::*;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

    state_t state_q, state_d;

    logic             load;
    logic             step;
    logic             finish;

    // q_r starts as the dividend and is shifted into R one bit per cycle while
    // the quotient bits fill in from the LSB side.
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] dvs_r;
    logic [WIDTH:0]   r_r;
    logic [CNT_W-1:0] cnt_r;
    logic             dbz_r;

    logic [WIDTH:0]   r_sh;
    logic [WIDTH-1:0] trial;
    logic             no_borrow;
    logic             trial_ok;

    assign r_sh = {r_r[WIDTH-1:0], q_r[WIDTH-1]};

    sub_32b u_sub (
        .a     (r_sh[WIDTH-1:0]),
        .b     (dvs_r),
        .c_in  (1'b0),
        .diff  (trial),
        .c_out (no_borrow)
    );

    // A set bit 32 means the shifted R already exceeds any 32-bit divisor.
    assign trial_ok = r_sh[WIDTH] | no_borrow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // done is checked in IDLE so a start coinciding with the done pulse is dropped.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !done) begin
                    load    = 1'b1;
                    state_d = (divisor == '0) ? ST_FIN : ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt_r == LAST_CNT) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                finish  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r         <= '0;
            dvs_r       <= '0;
            r_r         <= '0;
            cnt_r       <= '0;
            dbz_r       <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= finish;
            if (load) begin
                q_r   <= dividend;
                dvs_r <= divisor;
                r_r   <= '0;
                cnt_r <= '0;
                dbz_r <= (divisor == '0);
            end
            if (step) begin
                r_r <= trial_ok ? {1'b0, trial} : r_sh;
                q_r <= {q_r[WIDTH-2:0], trial_ok};
                if (cnt_r != LAST_CNT) begin
                    cnt_r <= cnt_r + 1'b1;
                end
            end
            if (finish) begin
                // On divide-by-zero q_r was never shifted, so it still holds the dividend.
                quotient    <= dbz_r ? DBZ_QUOTIENT : q_r;
                remainder   <= dbz_r ? q_r : r_r[WIDTH-1:0];
                div_by_zero <= dbz_r;
            end
        end
    end

endmodule

// File: tb/tb_div_32b_seq.sv
// tb/tb_div_32b_seq.sv - scoreboard bench for div_32b_seq
module tb_div_32b_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int          k;
        int          busy_base;
        int          lat;
        int          nbusy;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int busy_total = 0;

    div_32b_seq #(.WIDTH(32), .ITER(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (busy) busy_total++;
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient", quotient, e.q);
                check("remainder", remainder, e.r);
                check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
                check("latency", cyc - e.k, e.lat);
                check("busy_cycles", busy_total - e.busy_base - (busy ? 1 : 0), e.nbusy);
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er,
                         input logic edbz, input bit push);
        exp_t e;
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        // Scramble operands so any late sampling would corrupt the result.
        dividend = $urandom;
        divisor  = $urandom;
        if (push) begin
            e.q = eq;
            e.r = er;
            e.dbz = edbz;
            e.k = cyc;
            e.busy_base = busy_total;
            e.lat = edbz ? 1 : 33;
            e.nbusy = edbz ? 0 : 32;
            sb.push_back(e);
        end
    endtask

    // Leaves the caller at the negedge where done is observed high.
    task automatic wait_done;
        int t = 0;
        @(negedge clk);
        while (!done && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!done) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er, input logic edbz);
        issue(a, b, eq, er, edbz, 1'b1);
        wait_done();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #2;
        check("rst_quotient", quotient, 32'd0);
        check("rst_remainder", remainder, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        run(32'hFFFFFFFF, 32'h80000000, 32'd1, 32'h7FFFFFFF, 1'b0);
        run(32'd7, 32'h80000001, 32'd0, 32'd7, 1'b0);
        run(32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1);
        run(32'd0, 32'd1, 32'd0, 32'd0, 1'b0);
        run(32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0);
        run(32'h12345678, 32'd1000, 32'd305419, 32'd896, 1'b0);
        run(32'd3, 32'd7, 32'd0, 32'd3, 1'b0);

        // Starts during RUN and during the done cycle must both be dropped.
        issue(32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 1'b1);
        repeat (8) @(posedge clk);
        issue(32'd9, 32'd9, 32'd0, 32'd0, 1'b0, 1'b0);
        wait_done();
        start    = 1'b1;
        dividend = 32'd9;
        divisor  = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (40) @(negedge clk);
        check("held_quotient", quotient, 32'd333);
        check("held_remainder", remainder, 32'd1);
        check("held_busy", {31'd0, busy}, 32'd0);
        check("no_pending", sb.size(), 32'd0);

        // Reset partway through the iterations aborts without a done pulse.
        issue(32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 1'b1);
        repeat (15) @(posedge clk);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("abort_quotient", quotient, 32'd0);
        check("abort_remainder", remainder, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_no_done_quot", quotient, 32'd0);
        run(32'd50, 32'd5, 32'd10, 32'd0, 1'b0);
        check("final_pending", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
